// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared FSM state encoding and default constants for the
//                instruction memory loader.
//  Revision    : 1.0  initial release
// ============================================================================
package imem_loader_pkg;

    // Loader FSM states, explicitly 3 bits wide.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_WRITE   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERR     = 3'd7
    } state_t;

    localparam int          c_max_words_default = 256;
    localparam logic [15:0] c_base_addr_default = 16'h0000;

    // States in which the loader consumes a stream byte.
    function automatic logic is_byte_state(input state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
               (s == ST_DATA_HI) || (s == ST_DATA_LO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Byte-stream handshake plus instruction memory write bus.
//                master = loader side, slave = stream source / memory side.
//  Revision    : 1.0  initial release
// ============================================================================
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        im_we;
    logic [15:0] im_addr;
    logic [15:0] im_wdata;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, im_we, im_addr, im_wdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : imem_word_packer
//  Description : Assembles hi/lo stream bytes into a 16-bit word and keeps
//                the word index and the byte address of the next write.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_word_packer
    import imem_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = c_base_addr_default
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_clear,
    input  wire logic        i_load_hi,
    input  wire logic        i_load_lo,
    input  wire logic        i_inc,
    input  wire logic [7:0]  i_byte,
    output logic      [15:0] o_index,
    output logic      [15:0] o_addr,
    output logic      [15:0] o_wdata
);

    logic [7:0]  r_hi;
    logic [15:0] r_index;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;   // low half doubles as the lo byte register

    // Capture bytes; the low byte commits the whole word and its address so
    // both outputs change exactly when the FSM enters WRITE and hold after.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi    <= 8'h00;
            r_index <= 16'h0000;
            r_addr  <= BASE_ADDR;
            r_wdata <= 16'h0000;
        end else begin
            if (i_load_hi) begin
                r_hi <= i_byte;
            end
            if (i_load_lo) begin
                r_wdata <= {r_hi, i_byte};
                r_addr  <= BASE_ADDR + (r_index << 1);
            end
            if (i_clear) begin
                r_index <= 16'h0000;
            end else if (i_inc) begin
                r_index <= r_index + 16'd1;
            end
        end
    end

    assign o_index = r_index;
    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Loads a length-prefixed byte stream into instruction memory
//                as 16-bit words while holding the CPU.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          MAX_WORDS = c_max_words_default,
    parameter logic [15:0] BASE_ADDR = c_base_addr_default
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   start,
    input  wire logic   abort,
    imem_loader_if.master bus,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [16:0] c_max_words = 17'(MAX_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_count;
    logic [15:0] w_len;
    logic [15:0] w_index;
    logic        w_xfer;
    logic        w_last;
    logic        w_clear;
    logic        w_load_hi;
    logic        w_load_lo;
    logic        w_inc;
    logic        r_byte_ready;
    logic        r_im_we;
    logic        r_cpu_hold;
    logic        r_done;
    logic        r_error;

    assign w_xfer    = bus.byte_valid & r_byte_ready;
    assign w_len     = {r_count[15:8], bus.byte_data};
    assign w_last    = (w_index == (r_count - 16'd1));
    assign w_clear   = start & ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                (r_state == ST_ERR));
    // Abort wins over a same-cycle transfer, so the word is never committed.
    assign w_load_hi = w_xfer & ~abort & (r_state == ST_DATA_HI);
    assign w_load_lo = w_xfer & ~abort & (r_state == ST_DATA_LO);
    assign w_inc     = (r_state == ST_WRITE);

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) w_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (abort)       w_next = ST_ERR;
                else if (w_xfer) w_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (abort) begin
                    w_next = ST_ERR;
                end else if (w_xfer) begin
                    if (w_len == 16'h0000)                  w_next = ST_DONE;
                    else if ({1'b0, w_len} > c_max_words)   w_next = ST_ERR;
                    else                                    w_next = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (abort)       w_next = ST_ERR;
                else if (w_xfer) w_next = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                if (abort)       w_next = ST_ERR;
                else if (w_xfer) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (abort)       w_next = ST_ERR;
                else if (w_last) w_next = ST_DONE;
                else             w_next = ST_DATA_HI;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // FSM state register with outputs registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_byte_ready <= 1'b0;
            r_im_we      <= 1'b0;
            r_cpu_hold   <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_byte_ready <= is_byte_state(w_next);
            r_im_we      <= (w_next == ST_WRITE);
            r_cpu_hold   <= (w_next != ST_DONE);
            r_done       <= (w_next == ST_DONE);
            r_error      <= (w_next == ST_ERR);
        end
    end

    // Word count captured from the two length bytes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 16'h0000;
        end else if (w_xfer && !abort) begin
            if (r_state == ST_LEN_HI) r_count[15:8] <= bus.byte_data;
            if (r_state == ST_LEN_LO) r_count[7:0]  <= bus.byte_data;
        end
    end

    imem_word_packer #(
        .BASE_ADDR (BASE_ADDR)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_load_hi (w_load_hi),
        .i_load_lo (w_load_lo),
        .i_inc     (w_inc),
        .i_byte    (bus.byte_data),
        .o_index   (w_index),
        .o_addr    (bus.im_addr),
        .o_wdata   (bus.im_wdata)
    );

    assign bus.byte_ready = r_byte_ready;
    assign bus.im_we      = r_im_we;
    assign cpu_hold       = r_cpu_hold;
    assign done           = r_done;
    assign error          = r_error;

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MAX_WORDS, default 256, gives the instruction memory depth in 16-bit words.
REQ-002 Parameter BASE_ADDR, default 16'h0000, gives the byte address of the first loaded word.
REQ-003 Port clk, input, 1 bit, is the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit, is an asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit, is a one-cycle request to begin a load.
REQ-006 Port abort, input, 1 bit, cancels the load in progress.
REQ-007 Port byte_valid, input, 1 bit, means the source presents a stream byte.
REQ-008 Port byte_data, input, 8 bits, carries the stream byte.
REQ-009 Port byte_ready, output, 1 bit, means the loader accepts byte_data this cycle.
REQ-010 Port im_we, output, 1 bit, is the instruction memory write strobe.
REQ-011 Port im_addr, output, 16 bits, is the instruction memory byte address.
REQ-012 Port im_wdata, output, 16 bits, is the instruction word to write.
REQ-013 Port cpu_hold, output, 1 bit, keeps the CPU stalled or halted while high.
REQ-014 Port done, output, 1 bit, means the load completed.
REQ-015 Port error, output, 1 bit, means the load was rejected or aborted.

Function
REQ-016 A byte transfers only in a cycle where byte_valid and byte_ready are both high.
REQ-017 Stream format: word count high byte, then count low byte, then per word the high byte followed by the low byte.
REQ-018 FSM states and exits:
- IDLE: start goes to LEN_HI.
- LEN_HI: a transfer goes to LEN_LO.
- LEN_LO: a transfer goes to DONE if count=0, to ERR if count>MAX_WORDS, else to DATA_HI.
- DATA_HI: a transfer goes to DATA_LO.
- DATA_LO: a transfer goes to WRITE.
- WRITE: goes to DONE if this was the last word, else to DATA_HI.
- DONE or ERR: start goes to LEN_HI.
REQ-019 byte_ready is high only in LEN_HI, LEN_LO, DATA_HI and DATA_LO, so it is low in WRITE (backpressure).
REQ-020 In WRITE, im_we is high for exactly one cycle, with im_wdata = {hi,lo} and im_addr = BASE_ADDR + 2*index.
- The write happens one cycle after the low-byte transfer.
REQ-021 The word index starts at 0, increments after each WRITE, and im_addr is 16-bit wrap-around arithmetic.
REQ-022 Outside WRITE, im_we is 0; im_addr and im_wdata hold their last values.
REQ-023 cpu_hold is 1 in every state except DONE.
REQ-024 done is 1 only in DONE; error is 1 only in ERR.
REQ-025 start is ignored in LEN_HI, LEN_LO, DATA_HI, DATA_LO and WRITE.
REQ-026 abort in any load state goes to ERR next cycle.
- abort takes priority over a same-cycle byte transfer, and the word being assembled is discarded.
- abort is ignored in IDLE, DONE and ERR.
REQ-027 If start and abort are asserted together in DONE or ERR, start wins.
REQ-028 Throughput is 1 word per 3 cycles when byte_valid is held high.

Reset
REQ-029 When rst is low:
- state goes to IDLE and the index clears to 0;
- byte_ready, im_we, done and error are 0;
- im_addr = BASE_ADDR and im_wdata = 0;
- cpu_hold is 1.
REQ-030 Reset takes effect asynchronously, including mid-load, and no im_we pulse is produced during or after reset assertion.
REQ-031 Reset is released synchronously to clk; the first state change comes on the first clk edge after rst rises.

Structure
REQ-032 A shared package holds the FSM state enum and the default constants for MAX_WORDS and BASE_ADDR.
REQ-033 A single sub-module, imem_word_packer, holds the hi/lo byte registers and the word index/address counter.
- The FSM stays in imem_loader.

Verification
REQ-034 Stream 00 02 12 34 AB CD with byte_valid always high gives:
- im_we at addr 0x0000 with data 0x1234, then at addr 0x0002 with data 0xABCD;
- done=1 and cpu_hold=0 next cycle.
REQ-035 Stream 00 00 goes to DONE with no im_we pulse.
REQ-036 Stream 01 01 with MAX_WORDS=256 gives error=1, no im_we, and cpu_hold=1.
REQ-037 abort after byte 12 of word 0 gives ERR next cycle, no im_we, and error=1.
- A following start plus stream 00 01 55 AA then writes 0x55AA at 0x0000.
REQ-038 rst low during DATA_LO of word 3 gives:
- an immediate IDLE, im_we=0 and cpu_hold=1;
- no write after release.
REQ-039 byte_valid toggled randomly over a 4-word stream gives:
- writes identical to the no-gap case;
- no transfer ever accepted while in WRITE.
